mux_sync_arbiter: RTL and testbench

//   Round-robin arbiter/sequencer sharing one mux_sync CDC channel between
//   NUM_REQ requesters in the dst_clk domain. Serialises requests, drives the

---
 rtl/mux_sync_arbiter_if.sv | 26 ++
 rtl/mux_sync_arbiter.sv | 152 +++++++++++++++
 tb/tb_mux_sync_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mux_sync_arbiter_if.sv
// Handshake bundle between requesters, the arbiter and one mux_sync channel.
// slave = arbiter side, master = requester/channel side.
interface mux_sync_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            done;
    logic                          err_timeout;
    logic                          ch_en;
    logic [DATA_WIDTH-1:0]         ch_data;
    logic                          ch_ack;
    logic                          busy;

    modport slave (
        input  req, req_data, ch_ack,
        output gnt, done, err_timeout, ch_en, ch_data, busy
    );

    modport master (
        output req, req_data, ch_ack,
        input  gnt, done, err_timeout, ch_en, ch_data, busy
    );
endinterface

// File: rtl/mux_sync_arbiter.sv
// Round-robin sequencer sharing one mux_sync CDC channel between requesters.
// Launch, hold data until ack/timeout, then enforce a gap between pulses.
module mux_sync_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int USE_ACK     = 1,
    parameter int HOLD_CYCLES = 8,
    parameter int TIMEOUT     = 64
) (
    input logic               dst_clk,
    input logic               rst_n,
    mux_sync_arbiter_if.slave bus
);
    localparam int LW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CMAX = (TIMEOUT > HOLD_CYCLES) ? TIMEOUT : HOLD_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int LIM  = (USE_ACK != 0) ? TIMEOUT - 1 : HOLD_CYCLES - 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [LW-1:0]           last_q, last_d;
    logic [NUM_REQ-1:0]      own_q, own_d;
    logic [NUM_REQ-1:0]      gnt_q, gnt_d;
    logic [NUM_REQ-1:0]      done_q, done_d;
    logic                    err_q, err_d;
    logic                    en_q, en_d;
    logic                    busy_q, busy_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;

    logic [2*NUM_REQ-1:0]    req2, rot_full;
    logic [NUM_REQ-1:0]      rot, win_oh;
    logic [LW:0]             sh;
    logic [LW-1:0]           win;
    logic                    found;
    logic [DATA_WIDTH-1:0]   sel;
    logic                    ack_eff;
    logic [CW-1:0]           cnt_inc;

    // Rotate so bit 0 is the requester just after the last winner.
    assign req2     = {bus.req, bus.req};
    assign sh       = {1'b0, last_q} + (LW + 1)'(1);
    assign rot_full = req2 >> sh;
    assign rot      = rot_full[NUM_REQ-1:0];
    assign win_oh   = NUM_REQ'(1) << win;
    assign ack_eff  = (USE_ACK != 0) && bus.ch_ack;
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        found = 1'b0;
        win   = last_q;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                win   = LW'((int'(last_q) + 1 + i) % NUM_REQ);
            end
        end
    end

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == LW'(i)) begin
                sel = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        own_d   = own_q;
        gnt_d   = '0;
        done_d  = '0;
        err_d   = 1'b0;
        en_d    = 1'b0;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = LAUNCH;
                    gnt_d   = win_oh;
                    en_d    = 1'b1;
                    data_d  = sel;
                    own_d   = win_oh;
                    last_d  = win;
                end
            end
            LAUNCH: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (ack_eff) begin
                    state_d = GAP;
                    cnt_d   = '0;
                    done_d  = own_q;
                end else if (cnt_q == CW'(LIM)) begin
                    state_d = GAP;
                    cnt_d   = '0;
                    done_d  = own_q;
                    err_d   = (USE_ACK != 0);
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            GAP: begin
                if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge dst_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= LW'(NUM_REQ - 1);
            own_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            own_q   <= own_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.done        = done_q;
    assign bus.err_timeout = err_q;
    assign bus.ch_en       = en_q;
    assign bus.ch_data     = data_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_mux_sync_arbiter.sv
// Directed bench for mux_sync_arbiter: ack, timeout, RR order, resets,
// and a USE_ACK=0 build; grants checked against a scoreboard queue.
module tb_mux_sync_arbiter;
    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int HOLD = 8;
    localparam int TO   = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux_sync_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) if0 ();
    mux_sync_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) if1 ();

    mux_sync_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .USE_ACK(1),
        .HOLD_CYCLES(HOLD), .TIMEOUT(TO)
    ) u0 (.dst_clk(clk), .rst_n(rst_n), .bus(if0));

    mux_sync_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .USE_ACK(0),
        .HOLD_CYCLES(HOLD), .TIMEOUT(TO)
    ) u1 (.dst_clk(clk), .rst_n(rst_n), .bus(if1));

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [DW-1:0] d);
        if0.req[i] = 1'b1;
        if0.req_data[i*DW +: DW] = d;
    endtask

    task automatic push(input int i, input logic [DW-1:0] d);
        exp_t e;
        e.idx  = i;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        if0.req = '0; if0.req_data = '0; if0.ch_ack = 1'b0;
        if1.req = '0; if1.req_data = '0; if1.ch_ack = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_gnt(output int w);
        w = -1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (if0.gnt != '0) begin
                for (int k = 0; k < N; k++) if (if0.gnt[k]) w = k;
                break;
            end
        end
        if (w < 0) begin
            checks++;
            errors++;
            $error("FAIL gnt_wait observed none expected a grant");
        end
    endtask

    // d: cycle after the grant on which ack is sampled; to: expect timeout.
    task automatic serve(input int d, input bit to);
        int   w;
        exp_t e;
        wait_gnt(w);
        if (w < 0) return;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty observed gnt %0d expected none", w);
            return;
        end
        e = sb.pop_front();
        chk("gnt", 64'(if0.gnt), 64'(1) << e.idx);
        chk("ch_data", 64'(if0.ch_data), 64'(e.data));
        chk("ch_en", 64'(if0.ch_en), 64'(1));
        if0.req[w] = 1'b0;
        tick();
        chk("launch_pulse", 64'({if0.gnt, if0.ch_en}), 64'(0));
        if (to) begin
            repeat (TO - 1) tick();
            chk("pre_timeout_done", 64'(if0.done), 64'(0));
            tick();
        end else begin
            repeat (d - 1) tick();
            if0.ch_ack = 1'b1;
            tick();
            if0.ch_ack = 1'b0;
        end
        chk("done", 64'(if0.done), 64'(1) << e.idx);
        chk("err_timeout", 64'(if0.err_timeout), 64'(to));
        tick();
        chk("done_pulse", 64'({if0.done, if0.err_timeout}), 64'(0));
        if0.ch_ack = 1'b1;
        tick();
        if0.ch_ack = 1'b0;
        chk("gap_stray_ack", 64'({if0.done, if0.busy}), 64'(1));
        chk("ch_data_hold", 64'(if0.ch_data), 64'(e.data));
        repeat (5) tick();
        chk("busy_gap", 64'(if0.busy), 64'(1));
        tick();
        chk("busy_idle", 64'(if0.busy), 64'(0));
    endtask

    initial begin
        int w;
        bit got;
        do_reset();
        tick();
        chk("rst_ctl", 64'({if0.gnt, if0.done, if0.err_timeout,
                             if0.ch_en, if0.busy}), 64'(0));
        chk("rst_data", 64'(if0.ch_data), 64'(0));

        if0.ch_ack = 1'b1;
        tick();
        if0.ch_ack = 1'b0;
        tick();
        chk("idle_stray_ack", 64'({if0.gnt, if0.done, if0.busy}), 64'(0));

        set_req(0, 32'hA5A5_0001);
        push(0, 32'hA5A5_0001);
        serve(5, 1'b0);

        do_reset();
        for (int i = 0; i < N; i++) begin
            set_req(i, 32'hD000_0000 + 32'(i));
            push(i, 32'hD000_0000 + 32'(i));
        end
        repeat (N) serve(2, 1'b0);
        set_req(0, 32'hE000_0000);
        set_req(2, 32'hE000_0002);
        push(0, 32'hE000_0000);
        push(2, 32'hE000_0002);
        serve(3, 1'b0);
        serve(3, 1'b0);

        set_req(1, 32'hC000_0001);
        push(1, 32'hC000_0001);
        serve(0, 1'b1);
        set_req(3, 32'hC000_0003);
        push(3, 32'hC000_0003);
        serve(2, 1'b0);

        set_req(0, 32'hB000_0000);
        push(0, 32'hB000_0000);
        serve(TO, 1'b0);

        set_req(1, 32'hF000_0001);
        wait_gnt(w);
        chk("pre_rst_gnt", 64'(w), 64'(1));
        if0.req[1] = 1'b0;
        tick();
        set_req(1, 32'hF000_0005);
        set_req(3, 32'hF000_0003);
        repeat (2) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ctl", 64'({if0.gnt, if0.done, if0.err_timeout,
                                   if0.ch_en, if0.busy}), 64'(0));
        chk("async_rst_data", 64'(if0.ch_data), 64'(0));
        repeat (2) tick();
        rst_n = 1'b1;
        chk("post_rst", 64'({if0.done, if0.busy, if0.ch_data}), 64'(0));
        push(1, 32'hF000_0005);
        push(3, 32'hF000_0003);
        serve(2, 1'b0);
        serve(2, 1'b0);

        if1.req[0] = 1'b1;
        if1.req_data[DW-1:0] = 32'h0000_55AA;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (if1.gnt != '0) begin
                got = 1'b1;
                break;
            end
        end
        chk("noack_gnt", 64'({got, if1.gnt}), 64'(5'b1_0001));
        if1.req = '0;
        tick();
        if1.ch_ack = 1'b1;
        tick();
        if1.ch_ack = 1'b0;
        repeat (6) tick();
        chk("noack_early", 64'(if1.done), 64'(0));
        tick();
        chk("noack_done", 64'({if1.done, if1.err_timeout}), 64'(5'b0001_0));
        chk("noack_data", 64'(if1.ch_data), 64'(32'h0000_55AA));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
